// File: rtl/apb_pkg.sv
// apb_pkg: shared APB bridge types and constants.
package apb_pkg;
  localparam int APB_DATA_WIDTH = 32;
  localparam logic [APB_DATA_WIDTH-1:0] APB_ERR_RDATA = 32'hDEAD_BEEF;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_e;
endpackage

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-beat CPU requests to APB SETUP/ACCESS transfers with a ready timeout.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int TIMEOUT = 256,
  parameter logic [APB_DATA_WIDTH-1:0] ERR_RDATA = APB_ERR_RDATA
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_i,
  input  logic                      req_we_i,
  input  logic [ADDR_WIDTH-1:0]     req_addr_i,
  input  logic [APB_DATA_WIDTH-1:0] req_wdata_i,
  output logic                      req_gnt_o,
  output logic                      rsp_valid_o,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic [ADDR_WIDTH-1:0]     addr_o,
  output logic [APB_DATA_WIDTH-1:0] wdata_o,
  output logic                      write_o,
  output logic                      sel_o,
  output logic                      enable_o,
  input  logic [APB_DATA_WIDTH-1:0] rdata_i,
  input  logic                      ready_i
);
  localparam int CW = $clog2(TIMEOUT + 1);
  apb_state_e r_state;
  logic [CW-1:0] r_cnt;
  logic w_timeout;
  assign w_timeout = r_cnt == CW'(TIMEOUT - 1);
  // Bus strobes decode straight from the state register so reset drops them asynchronously.
  assign req_gnt_o = r_state == IDLE;
  assign sel_o = r_state == SETUP || r_state == ACCESS;
  assign enable_o = r_state == ACCESS;
  assign rsp_valid_o = r_state == RESP;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      addr_o <= '0;
      wdata_o <= '0;
      write_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o <= 1'b0;
    end else
      case (r_state)
        IDLE: if (req_i) begin
          addr_o <= req_addr_i;
          wdata_o <= req_wdata_i;
          write_o <= req_we_i;
          r_state <= SETUP;
        end
        SETUP: r_state <= ACCESS;
        ACCESS: if (ready_i || w_timeout) begin
          rsp_rdata_o <= write_o ? '0 : ready_i ? rdata_i : ERR_RDATA;
          rsp_err_o <= !ready_i;
          r_state <= RESP;
        end
        default: r_state <= IDLE;
      endcase
  // Counts ACCESS cycles; cleared on acceptance so SETUP starts from zero.
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (r_state == IDLE && req_i) r_cnt <= '0;
    else if (r_state == ACCESS) r_cnt <= r_cnt + 1'b1;
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: randomized self-checking bench for apb_master_bridge with TIMEOUT=4.
module tb_apb_master_bridge;
  localparam int TO = 4;
  logic clk = 0, rst = 1;
  logic req_i = 0, req_we_i = 0, req_gnt_o, rsp_valid_o, rsp_err_o, write_o, sel_o, enable_o;
  logic ready_i = 0;
  logic [11:0] req_addr_i = 0, addr_o;
  logic [31:0] req_wdata_i = 0, rsp_rdata_o, wdata_o, rdata_i = 0;
  int tests = 0, fails = 0, cyc = 0;
  int t_acc, t_sel, t_en, t_rsp;
  logic [31:0] o_rdata;
  logic o_err;
  bit proto_ok;

  apb_master_bridge #(.ADDR_WIDTH(12), .TIMEOUT(TO), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_gnt_o(req_gnt_o), .rsp_valid_o(rsp_valid_o),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .write_o(write_o), .sel_o(sel_o), .enable_o(enable_o), .rdata_i(rdata_i), .ready_i(ready_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: a slave that stalls `waits` cycles answers after 3+waits cycles unless the
  // timeout (TO ACCESS cycles) expires first, in which case the bridge answers at 2+TO.
  function automatic int exp_lat(input int waits);
    return (waits < TO) ? 3 + waits : 2 + TO;
  endfunction
  function automatic logic [31:0] exp_rdata(input logic we, input int waits, input logic [31:0] rd);
    return we ? 32'h0 : (waits < TO) ? rd : 32'hDEAD_BEEF;
  endfunction

  task automatic xfer(input logic we, input logic [11:0] a, input logic [31:0] wd,
                      input logic [31:0] rd, input int waits, input bit keep_req);
    int n, k;
    req_i = 1; req_we_i = we; req_addr_i = a; req_wdata_i = wd;
    n = 0;
    @(negedge clk);
    while (!req_gnt_o && n < 20) begin @(negedge clk); n++; end
    t_acc = cyc;
    @(posedge clk); #1;
    req_i = keep_req; req_we_i = 1'($urandom); req_addr_i = 12'($urandom); req_wdata_i = $urandom;
    proto_ok = 1; t_sel = -1; t_en = -1; t_rsp = -1; k = 0;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (sel_o && t_sel < 0) t_sel = cyc;
      if (enable_o && t_en < 0) t_en = cyc;
      if (sel_o && (addr_o !== a || wdata_o !== wd || write_o !== we)) proto_ok = 0;
      if ((enable_o && !sel_o) || req_gnt_o) proto_ok = 0;
      if (rsp_valid_o) begin
        t_rsp = cyc; o_rdata = rsp_rdata_o; o_err = rsp_err_o;
        if (sel_o || enable_o) proto_ok = 0;
        break;
      end
      if (enable_o) begin
        ready_i = k >= waits; rdata_i = ready_i ? rd : $urandom; k++;
      end else begin
        ready_i = 1'($urandom); rdata_i = $urandom;
      end
    end
    ready_i = 0;
  endtask

  task automatic test_reset;
    @(negedge clk); @(negedge clk);
    tests++; if (req_gnt_o !== 1'b1) begin fails++; $display("FAIL reset_gnt got %b want 1", req_gnt_o); end
    tests++; if ({sel_o, enable_o, rsp_valid_o, rsp_err_o, write_o} !== 5'b0) begin fails++; $display("FAIL reset_ctl got %b want 00000", {sel_o, enable_o, rsp_valid_o, rsp_err_o, write_o}); end
    tests++; if ({rsp_rdata_o, wdata_o, addr_o} !== 76'h0) begin fails++; $display("FAIL reset_data got %h %h %h want 0", rsp_rdata_o, wdata_o, addr_o); end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_read_zero_wait;
    xfer(1'b0, 12'h004, $urandom, 32'h0000_0041, 0, 0);
    tests++; if (t_sel - t_acc !== 1) begin fails++; $display("FAIL rd0_sel_cycle got %0d want 1", t_sel - t_acc); end
    tests++; if (t_en - t_acc !== 2) begin fails++; $display("FAIL rd0_en_cycle got %0d want 2", t_en - t_acc); end
    tests++; if (t_rsp - t_acc !== 3) begin fails++; $display("FAIL rd0_rsp_cycle got %0d want 3", t_rsp - t_acc); end
    tests++; if (o_rdata !== 32'h41 || o_err !== 1'b0) begin fails++; $display("FAIL rd0_rsp got %h/%b want 00000041/0", o_rdata, o_err); end
    tests++; if (!proto_ok) begin fails++; $display("FAIL rd0_proto got 0 want 1"); end
  endtask

  task automatic test_write_wait;
    xfer(1'b1, 12'h000, 32'h0000_0055, $urandom, 3, 0);
    tests++; if (t_rsp - t_acc !== 6) begin fails++; $display("FAIL wr3_rsp_cycle got %0d want 6", t_rsp - t_acc); end
    tests++; if (o_rdata !== 32'h0 || o_err !== 1'b0) begin fails++; $display("FAIL wr3_rsp got %h/%b want 00000000/0", o_rdata, o_err); end
    tests++; if (!proto_ok) begin fails++; $display("FAIL wr3_proto got 0 want 1"); end
  endtask

  task automatic test_ready_at_timeout;
    logic [31:0] rd;
    rd = $urandom;
    xfer(1'b0, 12'($urandom), $urandom, rd, TO - 1, 0);
    tests++; if (o_rdata !== rd || o_err !== 1'b0) begin fails++; $display("FAIL rdy_at_to got %h/%b want %h/0", o_rdata, o_err, rd); end
    tests++; if (t_rsp - t_acc !== exp_lat(TO - 1)) begin fails++; $display("FAIL rdy_at_to_cycle got %0d want %0d", t_rsp - t_acc, exp_lat(TO - 1)); end
  endtask

  task automatic test_timeout;
    xfer(1'b0, 12'h010, $urandom, $urandom, 100, 0);
    tests++; if (t_rsp - t_acc !== 2 + TO) begin fails++; $display("FAIL to_rd_cycle got %0d want %0d", t_rsp - t_acc, 2 + TO); end
    tests++; if (o_rdata !== 32'hDEAD_BEEF || o_err !== 1'b1) begin fails++; $display("FAIL to_rd_rsp got %h/%b want deadbeef/1", o_rdata, o_err); end
    tests++; if (!proto_ok) begin fails++; $display("FAIL to_rd_proto got 0 want 1"); end
    xfer(1'b1, 12'h020, $urandom, $urandom, 100, 0);
    tests++; if (o_rdata !== 32'h0 || o_err !== 1'b1) begin fails++; $display("FAIL to_wr_rsp got %h/%b want 00000000/1", o_rdata, o_err); end
  endtask

  task automatic test_hold;
    logic [31:0] rd;
    rd = $urandom;
    xfer(1'b0, 12'h008, $urandom, rd, 1, 0);
    repeat (3) @(negedge clk);
    tests++; if (rsp_valid_o !== 1'b0) begin fails++; $display("FAIL hold_pulse got %b want 0", rsp_valid_o); end
    tests++; if (rsp_rdata_o !== rd || rsp_err_o !== 1'b0) begin fails++; $display("FAIL hold_data got %h/%b want %h/0", rsp_rdata_o, rsp_err_o, rd); end
  endtask

  task automatic test_back_to_back;
    int a1, r2;
    bit ok;
    xfer(1'b0, 12'h004, $urandom, 32'h11, 0, 1);
    a1 = t_acc; ok = proto_ok;
    xfer(1'b0, 12'h008, $urandom, 32'h22, 0, 0);
    r2 = t_rsp;
    tests++; if (t_acc - a1 !== 4) begin fails++; $display("FAIL b2b_gnt got %0d want 4", t_acc - a1); end
    tests++; if (r2 + 1 - a1 !== 8) begin fails++; $display("FAIL b2b_total got %0d want 8", r2 + 1 - a1); end
    tests++; if (!(ok && proto_ok) || o_rdata !== 32'h22) begin fails++; $display("FAIL b2b_proto got %b%b/%h want 11/00000022", ok, proto_ok, o_rdata); end
  endtask

  task automatic test_random;
    int bad;
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      logic we;
      logic [31:0] rd;
      int w;
      we = 1'($urandom); rd = $urandom; w = $urandom_range(0, TO + 2);
      xfer(we, 12'($urandom), $urandom, rd, w, 1'($urandom));
      tests++;
      if (t_rsp - t_acc !== exp_lat(w) || o_rdata !== exp_rdata(we, w, rd) || o_err !== (w >= TO) || !proto_ok) begin
        fails++; bad++;
        $display("FAIL rand[%0d] we=%b w=%0d got lat %0d %h/%b proto %b want lat %0d %h/%b", i, we, w,
                 t_rsp - t_acc, o_rdata, o_err, proto_ok, exp_lat(w), exp_rdata(we, w, rd), w >= TO);
      end
    end
    req_i = 0;
  endtask

  task automatic test_reset_mid;
    int n;
    bit seen;
    @(negedge clk);
    req_i = 1; req_we_i = 0; req_addr_i = 12'h0C0;
    n = 0;
    @(negedge clk);
    while (!enable_o && n < 10) begin @(negedge clk); n++; end
    req_i = 0;
    tests++; if (enable_o !== 1'b1) begin fails++; $display("FAIL rstmid_access got %b want 1", enable_o); end
    #1 rst = 1; #1;
    tests++; if (sel_o !== 1'b0 || enable_o !== 1'b0) begin fails++; $display("FAIL rstmid_async got %b%b want 00", sel_o, enable_o); end
    @(negedge clk); rst = 0;
    seen = 0;
    repeat (4) begin @(negedge clk); if (rsp_valid_o) seen = 1; end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL rstmid_rsp got 1 want 0"); end
    tests++; if (req_gnt_o !== 1'b1 || rsp_rdata_o !== 32'h0) begin fails++; $display("FAIL rstmid_idle got %b/%h want 1/00000000", req_gnt_o, rsp_rdata_o); end
    xfer(1'b0, 12'h004, $urandom, 32'h77, 0, 0);
    tests++; if (o_rdata !== 32'h77 || t_rsp - t_acc !== 3) begin fails++; $display("FAIL rstmid_recover got %h lat %0d want 00000077 lat 3", o_rdata, t_rsp - t_acc); end
  endtask

  initial begin
    test_reset;
    test_read_zero_wait;
    test_write_wait;
    test_ready_at_timeout;
    test_timeout;
    test_hold;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
